// File: rtl/keypad_time_entry.sv
// keypad_time_entry: collects keypad presses into a 6-digit BCD time HH:MM:SS.
// It validates the time on enter and publishes it with a one-hot target strobe.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   key_valid, key_code     one-cycle key strobe; 0-9 digit, A/B/C target,
//                           D backspace, E clear, F enter
//   keypad_clock [23:0]     last committed time {H1,H0,M1,M0,S1,S0}, BCD
//   enable [3:0]            one-cycle commit strobe: 0100 setclock,
//                           0010 stopwatch, 0001 alarm
//   entry_buf [23:0]        in-progress digits, right-aligned, for the display
//   digit_count [2:0]       digits entered, 0-6
//   mode [1:0]              0 none, 1 setclock, 2 stopwatch, 3 alarm
//   error                   one-cycle pulse on a rejected key or a bad time
module keypad_time_entry #(
  parameter int unsigned TIMEOUT = 500000000,
  parameter int unsigned TO_W    = 29
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [23:0] keypad_clock,
  output logic [3:0]  enable,
  output logic [23:0] entry_buf,
  output logic [2:0]  digit_count,
  output logic [1:0]  mode,
  output logic        error
);

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BUF_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned EN_W   = 4;

  // Counter value at which the next idle edge completes TIMEOUT idle cycles.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  localparam logic [3:0] K_DIGIT_MAX = 4'd9;
  localparam logic [3:0] K_TGT_CLOCK = 4'hA;
  localparam logic [3:0] K_TGT_ALARM = 4'hC;
  localparam logic [3:0] K_BACK      = 4'hD;
  localparam logic [3:0] K_CLEAR     = 4'hE;
  localparam logic [3:0] K_ENTER     = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [BUF_W-1:0]  keypad_clock_q, keypad_clock_d;
  logic [EN_W-1:0]   enable_q, enable_d;
  logic [BUF_W-1:0]  entry_buf_q, entry_buf_d;
  logic [CNT_W-1:0]  digit_count_q, digit_count_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              error_q, error_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  // Key classification (all qualified by key_valid).
  logic              key_digit_c;
  logic              key_target_c;
  logic              key_back_c;
  logic              key_clear_c;
  logic              key_enter_c;
  logic [MODE_W-1:0] key_mode_c;

  assign key_digit_c  = key_valid && (key_code <= K_DIGIT_MAX);
  assign key_target_c = key_valid && (key_code >= K_TGT_CLOCK) && (key_code <= K_TGT_ALARM);
  assign key_back_c   = key_valid && (key_code == K_BACK);
  assign key_clear_c  = key_valid && (key_code == K_CLEAR);
  assign key_enter_c  = key_valid && (key_code == K_ENTER);
  // A/B/C map onto mode 1/2/3.
  assign key_mode_c   = MODE_W'(key_code - 4'h9);

  // Time validation on the right-aligned buffer: HH <= 23, M1 <= 5, S1 <= 5.
  logic [3:0] h1_c, h0_c, m1_c, s1_c;
  logic       time_ok_c;

  assign h1_c = entry_buf_q[23:20];
  assign h0_c = entry_buf_q[19:16];
  assign m1_c = entry_buf_q[15:12];
  assign s1_c = entry_buf_q[7:4];

  assign time_ok_c = ((h1_c < 4'd2) || ((h1_c == 4'd2) && (h0_c <= 4'd3)))
                     && (m1_c <= 4'd5) && (s1_c <= 4'd5);

  // Idle timeout fires on the edge that completes TIMEOUT key-free cycles.
  logic to_expire_c;

  assign to_expire_c = (TIMEOUT != 0) && (state_q == ST_ENTRY) && (to_cnt_q == TO_LAST);

  function automatic logic [EN_W-1:0] mode_onehot(input logic [MODE_W-1:0] m);
    logic [EN_W-1:0] oh;
    oh = '0;
    case (m)
      2'd1:    oh = 4'b0100;
      2'd2:    oh = 4'b0010;
      2'd3:    oh = 4'b0001;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a key on the same edge as the timeout takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (key_target_c) begin
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_enter_c && time_ok_c) begin
          state_d = ST_COMMIT;
        end else if (!key_valid && to_expire_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    keypad_clock_d = keypad_clock_q;
    enable_d       = '0;
    entry_buf_d    = entry_buf_q;
    digit_count_d  = digit_count_q;
    mode_d         = mode_q;
    error_d        = 1'b0;
    to_cnt_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (key_target_c) begin
          mode_d        = key_mode_c;
          entry_buf_d   = '0;
          digit_count_d = '0;
        end else if (key_valid && !key_clear_c) begin
          // Digits, backspace and enter mean nothing without a target.
          error_d = 1'b1;
        end
      end

      ST_ENTRY: begin
        if (key_valid) begin
          if (key_digit_c) begin
            if (digit_count_q < CNT_W'(DIGITS)) begin
              entry_buf_d   = {entry_buf_q[BUF_W-5:0], key_code};
              digit_count_d = digit_count_q + CNT_W'(1);
            end else begin
              error_d = 1'b1;
            end
          end else if (key_target_c) begin
            mode_d        = key_mode_c;
            entry_buf_d   = '0;
            digit_count_d = '0;
          end else if (key_back_c) begin
            if (digit_count_q != '0) begin
              entry_buf_d   = {4'h0, entry_buf_q[BUF_W-1:4]};
              digit_count_d = digit_count_q - CNT_W'(1);
            end
          end else if (key_clear_c) begin
            entry_buf_d   = '0;
            digit_count_d = '0;
          end else if (key_enter_c) begin
            if (time_ok_c) begin
              keypad_clock_d = entry_buf_q;
              enable_d       = mode_onehot(mode_q);
            end else begin
              error_d = 1'b1;
            end
          end
        end else if (to_expire_c) begin
          mode_d        = '0;
          entry_buf_d   = '0;
          digit_count_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_COMMIT: begin
        // Keys arriving here are dropped; the entry context is released.
        mode_d        = '0;
        entry_buf_d   = '0;
        digit_count_d = '0;
      end

      default: begin
        mode_d        = '0;
        entry_buf_d   = '0;
        digit_count_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keypad_clock_q <= '0;
      enable_q       <= '0;
      entry_buf_q    <= '0;
      digit_count_q  <= '0;
      mode_q         <= '0;
      error_q        <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      keypad_clock_q <= keypad_clock_d;
      enable_q       <= enable_d;
      entry_buf_q    <= entry_buf_d;
      digit_count_q  <= digit_count_d;
      mode_q         <= mode_d;
      error_q        <= error_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign keypad_clock = keypad_clock_q;
  assign enable       = enable_q;
  assign entry_buf    = entry_buf_q;
  assign digit_count  = digit_count_q;
  assign mode         = mode_q;
  assign error        = error_q;

endmodule
